branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the combinational branch resolver: adds a direct-mapped branch target buffer (BTB) with saturating taken/not-taken counters.
- Fetch side: gives a next-PC prediction for the fetch PC in the same cycle.
- Execute side: takes the resolved outcome, updates the tables, and raises a registered redirect on misprediction.
- Sits between the fetch PC mux and the execute-stage branch resolution.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 16, BTB depth; must be a power of two, 2..256.
- CNT_BITS, 2, saturating counter width; must be 1..3.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_flush_tbl  in  1  invalidate all BTB entries.
- i_fetch_pc  in  XLEN  PC being fetched.
- o_pred_taken  out  1  combinational prediction.
- o_pred_pc  out  XLEN  combinational predicted next PC.
- i_upd_valid  in  1  resolved control-flow instruction this cycle.
- i_upd_pc  in  XLEN  PC of the resolved instruction.
- i_upd_uncond  in  1  1 for JAL/JALR, 0 for conditional BRANCH.
- i_upd_taken  in  1  resolved direction.
- i_upd_target  in  XLEN  resolved target.
- i_upd_pred_pc  in  XLEN  next PC that fetch predicted for this instruction.
- o_redirect  out  1  registered misprediction pulse.
- o_redirect_pc  out  XLEN  registered correct next PC.
- o_mispred_cnt  out  32  misprediction counter.
- o_update_cnt  out  32  resolved-instruction counter.

Behaviour:
- Addressing:
  - IW = log2(ENTRIES).
  - index = pc[IW+1:2]; tag = pc[XLEN-1:IW+2].
  - pc[1:0] are ignored.
- Entry contents: valid, tag, target[XLEN-1:0], cnt[CNT_BITS-1:0].
- Lookup (combinational from registered state):
  - hit = valid && tag match.
  - o_pred_taken = hit && cnt[MSB].
  - o_pred_pc = o_pred_taken ? target : i_fetch_pc + 4 (modulo 2^XLEN).
- Update, on the rising edge when i_upd_valid:
  - Resolved next PC: rnpc = i_upd_taken ? i_upd_target : i_upd_pc + 4.
  - Hit, taken: cnt saturating-increments (max 2^CNT_BITS-1); target <= i_upd_target.
  - Hit, not taken: cnt saturating-decrements (min 0).
  - Hit, i_upd_uncond: cnt <= max.
  - Miss, taken: allocate (overwrite, no replacement choice). valid <= 1, tag, target set. cnt <= max if uncond, else 2^(CNT_BITS-1) (weakly taken).
  - Miss, not taken: no table write.
- Redirect:
  - Next cycle, o_redirect = (rnpc != i_upd_pred_pc) and o_redirect_pc = rnpc.
  - Otherwise o_redirect = 0 and o_redirect_pc holds its last value.
  - Latency: exactly 1 cycle; o_redirect is a single-cycle pulse per mispredicted update.
- Counters:
  - o_update_cnt increments on every i_upd_valid.
  - o_mispred_cnt increments when the redirect condition is true.
  - Both wrap modulo 2^32.
- Simultaneous events:
  - Lookup and update to the same index in one cycle: lookup returns the pre-update entry (write-after-read).
  - i_flush_tbl with i_upd_valid: flush wins for table state (all valid <= 0, no allocate). Redirect and counters still compute from the update.
  - i_rst has priority over everything.
- Reset (synchronous):
  - All valid <= 0; all cnt <= 2^(CNT_BITS-1)-1 (weakly not taken).
  - o_redirect <= 0, o_redirect_pc <= 0, both counters <= 0.
  - Targets/tags need not reset.
  - Reset mid-stream drops any pending redirect: o_redirect is 0 the cycle after reset.
- No X on outputs after reset: o_pred_* are defined because valid is cleared.

Test Plan:
- Cold start: after reset, i_fetch_pc=0x100 -> o_pred_taken=0, o_pred_pc=0x104. Counters read 0.
- Allocate: update pc=0x100, taken, target=0x80, pred_pc=0x104 -> next cycle o_redirect=1, o_redirect_pc=0x80, o_mispred_cnt=1. Then fetch 0x100 -> pred_taken=1, pred_pc=0x80.
- Hysteresis (CNT_BITS=2): after allocate, one not-taken update (pred_pc=0x80) -> redirect to 0x104, cnt=1, fetch 0x100 predicts 0x104. Two taken updates -> cnt=3. One not-taken -> still predicts 0x80.
- Aliasing, ENTRIES=16: allocate 0x100 -> 0x80, then allocate 0x140 (same index 0, different tag) -> 0x200. Fetch 0x100 -> miss, predicts 0x104. Fetch 0x140 -> predicts 0x200.
- Same-cycle lookup/update plus flush: fetch 0x100 while updating 0x100 -> lookup shows old entry. Assert i_flush_tbl together with a taken update -> table empty next cycle, o_update_cnt still increments.
- JAL/wrap: uncond update pc=0xFFFFFFFC, target=0x0 -> cnt=max. Fetch 0xFFFFFFFC predicts 0x0. A not-taken lookup at that PC gives pc+4 wrapping to 0x0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with saturating direction counters,
// same-cycle fetch prediction and a registered redirect on misprediction.
module branch_predict_unit #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CNT_BITS = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush_tbl,
  input  logic [XLEN-1:0] i_fetch_pc,
  output logic            o_pred_taken,
  output logic [XLEN-1:0] o_pred_pc,
  input  logic            i_upd_valid,
  input  logic [XLEN-1:0] i_upd_pc,
  input  logic            i_upd_uncond,
  input  logic            i_upd_taken,
  input  logic [XLEN-1:0] i_upd_target,
  input  logic [XLEN-1:0] i_upd_pred_pc,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [31:0]     o_mispred_cnt,
  output logic [31:0]     o_update_cnt
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = XLEN - IW - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(2 ** (CNT_BITS - 1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(2 ** (CNT_BITS - 1) - 1);

  if ((ENTRIES < 2) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
    $error("branch_predict_unit: ENTRIES must be a power of two in 2..256");
  end
  if ((CNT_BITS < 1) || (CNT_BITS > 3)) begin : g_bad_cnt
    $error("branch_predict_unit: CNT_BITS must be 1..3");
  end

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_BITS'(1);
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_dec(input logic [CNT_BITS-1:0] c);
    return (c == {CNT_BITS{1'b0}}) ? c : c - CNT_BITS'(1);
  endfunction

  logic            valid_q  [ENTRIES];
  logic [TW-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q [ENTRIES];

  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [31:0]     mispred_cnt_q, mispred_cnt_d;
  logic [31:0]     update_cnt_q, update_cnt_d;

  logic [IW-1:0]       f_idx;
  logic [TW-1:0]       f_tag;
  logic                f_hit;
  logic [IW-1:0]       u_idx;
  logic [TW-1:0]       u_tag;
  logic                u_hit;
  logic [XLEN-1:0]     rnpc;
  logic                wr_en;
  logic [CNT_BITS-1:0] cnt_new;

  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_fetch_pc[1:0], i_upd_pc[1:0]};

  // Fetch-side lookup reads only registered table state (write-after-read).
  always_comb begin
    f_idx        = i_fetch_pc[IW+1:2];
    f_tag        = i_fetch_pc[XLEN-1:IW+2];
    f_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    o_pred_taken = f_hit && cnt_q[f_idx][CNT_BITS-1];
    if (o_pred_taken) begin
      o_pred_pc = target_q[f_idx];
    end else begin
      o_pred_pc = i_fetch_pc + XLEN'(4);
    end
  end

  // Execute-side update: table write decision, new counter, redirect and statistics.
  always_comb begin
    u_idx   = i_upd_pc[IW+1:2];
    u_tag   = i_upd_pc[XLEN-1:IW+2];
    u_hit   = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    rnpc    = i_upd_taken ? i_upd_target : (i_upd_pc + XLEN'(4));
    wr_en   = i_upd_valid && !i_flush_tbl && (u_hit || i_upd_taken);
    cnt_new = cnt_q[u_idx];
    if (u_hit) begin
      if (i_upd_uncond) begin
        cnt_new = CNT_MAX;
      end else if (i_upd_taken) begin
        cnt_new = sat_inc(cnt_q[u_idx]);
      end else begin
        cnt_new = sat_dec(cnt_q[u_idx]);
      end
    end else begin
      cnt_new = i_upd_uncond ? CNT_MAX : CNT_WT;
    end

    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    mispred_cnt_d = mispred_cnt_q;
    update_cnt_d  = update_cnt_q;
    if (i_upd_valid) begin
      redirect_d    = (rnpc != i_upd_pred_pc);
      redirect_pc_d = rnpc;
      update_cnt_d  = update_cnt_q + 32'd1;
      if (rnpc != i_upd_pred_pc) begin
        mispred_cnt_d = mispred_cnt_q + 32'd1;
      end else begin
        mispred_cnt_d = mispred_cnt_q;
      end
    end else begin
      redirect_d = 1'b0;
    end
  end

  // BTB storage; flush beats a concurrent allocate, reset beats everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (i_flush_tbl) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[u_idx] <= 1'b1;
      tag_q[u_idx]   <= u_tag;
      cnt_q[u_idx]   <= cnt_new;
      if (i_upd_taken) begin
        target_q[u_idx] <= i_upd_target;
      end
    end
  end

  // Redirect pulse and statistics registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      mispred_cnt_q <= 32'd0;
      update_cnt_q  <= 32'd0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      mispred_cnt_q <= mispred_cnt_d;
      update_cnt_q  <= update_cnt_d;
    end
  end

  assign o_redirect    = redirect_q;
  assign o_redirect_pc = redirect_pc_q;
  assign o_mispred_cnt = mispred_cnt_q;
  assign o_update_cnt  = update_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed stimulus pushes cycle-tagged
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_branch_predict_unit;

  localparam int K_PTAKEN = 0;
  localparam int K_PPC    = 1;
  localparam int K_RED    = 2;
  localparam int K_RPC    = 3;
  localparam int K_MIS    = 4;
  localparam int K_UPD    = 5;

  logic        clk = 1'b0;
  logic        i_rst, i_flush_tbl, i_upd_valid, i_upd_uncond, i_upd_taken;
  logic [31:0] i_fetch_pc, i_upd_pc, i_upd_target, i_upd_pred_pc;
  logic        o_pred_taken, o_redirect;
  logic [31:0] o_pred_pc, o_redirect_pc, o_mispred_cnt, o_update_cnt;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_BITS(2)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_flush_tbl  (i_flush_tbl),
    .i_fetch_pc   (i_fetch_pc),
    .o_pred_taken (o_pred_taken),
    .o_pred_pc    (o_pred_pc),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_uncond (i_upd_uncond),
    .i_upd_taken  (i_upd_taken),
    .i_upd_target (i_upd_target),
    .i_upd_pred_pc(i_upd_pred_pc),
    .o_redirect   (o_redirect),
    .o_redirect_pc(o_redirect_pc),
    .o_mispred_cnt(o_mispred_cnt),
    .o_update_cnt (o_update_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   exp_mis = 0;
  int   exp_upd = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input int k, input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_PTAKEN: return {31'd0, o_pred_taken};
      K_PPC:    return o_pred_pc;
      K_RED:    return {31'd0, o_redirect};
      K_RPC:    return o_redirect_pc;
      K_MIS:    return o_mispred_cnt;
      K_UPD:    return o_update_cnt;
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin : monitor
    int i;
    logic [31:0] act;
    i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].cyc == cyc) begin
        act = actual(sbq[i].kind);
        n_checks++;
        if (act !== sbq[i].val) begin
          $display("FAIL %s @cyc %0d: got 0x%08h, expected 0x%08h", sbq[i].name, cyc, act, sbq[i].val);
        end else begin
          n_pass++;
        end
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    i_rst       = 1'b0;
    i_flush_tbl = 1'b0;
    i_upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_taken, input logic [31:0] exp_pc);
    i_fetch_pc = pc;
    push(cyc, K_PTAKEN, {31'd0, exp_taken}, "pred_taken");
    push(cyc, K_PPC, exp_pc, "pred_pc");
  endtask

  task automatic upd(input logic [31:0] pc, input logic unc, input logic tk,
                     input logic [31:0] tgt, input logic [31:0] pred,
                     input logic exp_red, input logic [31:0] exp_rpc);
    i_upd_valid   = 1'b1;
    i_upd_pc      = pc;
    i_upd_uncond  = unc;
    i_upd_taken   = tk;
    i_upd_target  = tgt;
    i_upd_pred_pc = pred;
    exp_upd++;
    if (exp_red) exp_mis++;
    push(cyc + 1, K_RED, {31'd0, exp_red}, "redirect");
    if (exp_red) push(cyc + 1, K_RPC, exp_rpc, "redirect_pc");
    push(cyc + 1, K_MIS, 32'(exp_mis), "mispred_cnt");
    push(cyc + 1, K_UPD, 32'(exp_upd), "update_cnt");
  endtask

  initial begin
    i_rst = 1'b1; i_flush_tbl = 1'b0; i_upd_valid = 1'b0;
    i_fetch_pc = 32'h0; i_upd_pc = 32'h0; i_upd_uncond = 1'b0; i_upd_taken = 1'b0;
    i_upd_target = 32'h0; i_upd_pred_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    // Cold start
    lookup(32'h100, 1'b0, 32'h104);
    push(cyc, K_RED, 32'd0, "reset_redirect");
    push(cyc, K_RPC, 32'd0, "reset_redirect_pc");
    push(cyc, K_MIS, 32'd0, "reset_mispred_cnt");
    push(cyc, K_UPD, 32'd0, "reset_update_cnt");

    // Allocate, then predict from the new entry
    next_cycle(); upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
    next_cycle(); lookup(32'h100, 1'b1, 32'h80);

    // Hysteresis
    next_cycle(); push(cyc, K_RED, 32'd0, "redirect_single_pulse");
    upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80, 1'b1, 32'h104);
    next_cycle(); lookup(32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
    next_cycle(); lookup(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h80, 1'b0, 32'h0);
    next_cycle(); lookup(32'h100, 1'b1, 32'h80);
    upd(32'h100, 1'b0, 1'b0, 32'h80, 32'h80, 1'b1, 32'h104);
    next_cycle(); lookup(32'h100, 1'b1, 32'h80);

    // Aliasing on index 0
    next_cycle(); upd(32'h140, 1'b0, 1'b1, 32'h200, 32'h144, 1'b1, 32'h200);
    next_cycle(); lookup(32'h100, 1'b0, 32'h104);
    next_cycle(); lookup(32'h140, 1'b1, 32'h200);

    // Flush with a concurrent taken update
    next_cycle(); i_flush_tbl = 1'b1;
    upd(32'h100, 1'b0, 1'b1, 32'h80, 32'h104, 1'b1, 32'h80);
    lookup(32'h140, 1'b1, 32'h200);
    next_cycle(); lookup(32'h140, 1'b0, 32'h144);
    next_cycle(); lookup(32'h100, 1'b0, 32'h104);

    // JAL at top of address space, PC wrap
    next_cycle(); lookup(32'hFFFF_FFFC, 1'b0, 32'h0);
    upd(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle(); lookup(32'hFFFF_FFFC, 1'b1, 32'h0);
    upd(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle(); lookup(32'hFFFF_FFFC, 1'b1, 32'h0);

    // Reset together with a mispredicted update drops the redirect
    next_cycle(); i_rst = 1'b1;
    i_upd_valid = 1'b1; i_upd_pc = 32'h300; i_upd_uncond = 1'b0; i_upd_taken = 1'b1;
    i_upd_target = 32'h400; i_upd_pred_pc = 32'h304;
    exp_mis = 0; exp_upd = 0;
    push(cyc + 1, K_RED, 32'd0, "rst_drops_redirect");
    push(cyc + 1, K_RPC, 32'd0, "rst_redirect_pc");
    push(cyc + 1, K_MIS, 32'd0, "rst_mispred_cnt");
    push(cyc + 1, K_UPD, 32'd0, "rst_update_cnt");
    next_cycle(); lookup(32'hFFFF_FFFC, 1'b0, 32'h0);
    next_cycle(); lookup(32'h100, 1'b0, 32'h104);

    #1;
    n_checks++;
    if (o_pred_taken !== 1'b0) begin
      $display("FAIL direct_pred_taken: got %0b, expected 0", o_pred_taken);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (o_pred_pc !== 32'h104) begin
      $display("FAIL direct_pred_pc: got 0x%08h, expected 0x00000104", o_pred_pc);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (o_redirect !== 1'b0) begin
      $display("FAIL direct_redirect: got %0b, expected 0", o_redirect);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (o_mispred_cnt !== 32'd0) begin
      $display("FAIL direct_mispred_cnt: got 0x%08h, expected 0x00000000", o_mispred_cnt);
    end else begin
      n_pass++;
    end
    n_checks++;
    if (o_update_cnt !== 32'd0) begin
      $display("FAIL direct_update_cnt: got 0x%08h, expected 0x00000000", o_update_cnt);
    end else begin
      n_pass++;
    end

    repeat (3) next_cycle();
    while (sbq.size() > 0) begin
      n_checks++;
      $display("FAIL unchecked_%s: due cyc %0d, expected 0x%08h never compared", sbq[0].name, sbq[0].cyc, sbq[0].val);
      sbq.delete(0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
